dram_arbiter: RTL

- Shares the single-port byte-addressed DRAM model (32-bit word access, 1-cycle registered read) between NUM_REQ requesters, e.g. weight loader, ifmap loader and psum writeback.
- Round-robin arbitration of burst commands; sequences word addresses, write-data handshakes and read-data return for the granted requester.
- Sits between the PE-array loaders/writers and the DRAM instance in the controller.

---
 rtl/dram_ctrl_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/dram_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the DRAM arbiter slice:
// FSM state encoding, word size and default bus widths.
package dram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_e;

    localparam int WORD_BYTES     = 4;
    localparam int DEF_NUM_REQ    = 3;
    localparam int DEF_ADDR_WIDTH = 20;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: highest priority at i_ptr, rotating up.
// Ports: i_req (request vector), i_ptr (start index),
//        o_gnt (one-hot grant, 0 if no request), o_idx (grant index).
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [PW-1:0]      o_idx
);

    logic w_found;
    int   w_k;

    // First pass covers [ptr, N-1], second pass wraps to [0, N-1].
    always_comb begin
        w_found = 1'b0;
        w_k     = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && i_req[j] && (j >= int'(i_ptr))) begin
                w_found = 1'b1;
                w_k     = j;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && i_req[j]) begin
                w_found = 1'b1;
                w_k     = j;
            end
        end
        o_idx = PW'(w_k);
        o_gnt = w_found ? (NUM_REQ'(1) << w_k) : '0;
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin burst arbiter sharing one single-port DRAM between NUM_REQ
// requesters. Ports: per-requester cmd_* / w* / rvalid / done, shared rdata,
// and the dram_* interface (1-cycle registered read on dram_dout).
module dram_arbiter
    import dram_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              cmd_valid,
    output logic [NUM_REQ-1:0]              cmd_ready,
    input  logic [NUM_REQ-1:0]              cmd_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    cmd_len,
    input  logic [NUM_REQ-1:0]              wvalid,
    output logic [NUM_REQ-1:0]              wready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]              rvalid,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic [NUM_REQ-1:0]              done,
    output logic                            dram_we,
    output logic [ADDR_WIDTH-1:0]           dram_addr,
    output logic [DATA_WIDTH-1:0]           dram_din,
    input  logic [DATA_WIDTH-1:0]           dram_dout
);

    localparam int PW = $clog2(NUM_REQ);

    logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
    logic [LEN_WIDTH-1:0]  w_len   [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_addr[i]  = cmd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_len[i]   = cmd_len[i*LEN_WIDTH +: LEN_WIDTH];
        assign w_wdata[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    state_e                r_state;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         r_gidx;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [DATA_WIDTH-1:0] r_din_q;
    logic                  r_rvalid;

    logic [NUM_REQ-1:0]    w_gnt;
    logic [PW-1:0]         w_idx;
    logic [NUM_REQ-1:0]    w_oh;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_last;
    logic [PW-1:0]         w_ptr_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr (
        .i_req (cmd_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_oh      = NUM_REQ'(1) << r_gidx;
    assign w_accept  = (r_state == IDLE) && (|cmd_valid);
    // A read beat issues every BURST cycle; a write beat only with wvalid.
    assign w_issue   = (r_state == BURST) && (!r_we || wvalid[r_gidx]);
    assign w_last    = w_issue && (r_rem == LEN_WIDTH'(1));
    assign w_ptr_nxt = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_gidx   <= '0;
            r_we     <= 1'b0;
            r_cur    <= '0;
            r_rem    <= '0;
            r_addr_q <= '0;
            r_din_q  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_issue && !r_we;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_gidx  <= w_idx;
                        r_we    <= cmd_we[w_idx];
                        r_cur   <= w_addr[w_idx] & ~ADDR_WIDTH'(WORD_BYTES - 1);
                        r_rem   <= w_len[w_idx];
                        r_ptr   <= w_ptr_nxt;
                        r_state <= (w_len[w_idx] != '0) ? BURST : DRAIN;
                    end
                end
                BURST: begin
                    if (w_issue) begin
                        r_cur    <= r_cur + ADDR_WIDTH'(WORD_BYTES);
                        r_rem    <= r_rem - LEN_WIDTH'(1);
                        r_addr_q <= r_cur;
                        if (r_we) begin
                            r_din_q <= w_wdata[r_gidx];
                        end
                    end
                    if (w_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // rst_n gate keeps cmd_ready low while reset is held with cmd_valid up.
    assign cmd_ready = (w_accept && rst_n) ? w_gnt : '0;
    assign wready    = ((r_state == BURST) && r_we) ? w_oh : '0;
    assign rvalid    = r_rvalid ? w_oh : '0;
    assign rdata     = r_rvalid ? dram_dout : '0;
    assign done      = (r_state == DRAIN) ? w_oh : '0;
    assign dram_we   = w_issue && r_we;
    // Address/data are live while a beat issues, otherwise hold last value.
    assign dram_addr = w_issue ? r_cur : r_addr_q;
    assign dram_din  = (w_issue && r_we) ? w_wdata[r_gidx] : r_din_q;

endmodule
